// File: rtl/tmnt_palette_mixer_if.sv
`default_nettype none
// ============================================================================
// Module      : tmnt_palette_mixer_if
// Description : 68000-side palette/priority bus bundle for tmnt_palette_mixer.
//               master = CPU side, slave = mixer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface tmnt_palette_mixer_if #(
    parameter int PAL_AW = 10
);
    logic              PAL_CS;
    logic              PRI_CS;
    logic              NREAD;
    logic [PAL_AW:0]   AB;
    logic [7:0]        DB_IN;
    logic [7:0]        DB_OUT;
    logic              nDTACK;

    modport master (
        output PAL_CS, PRI_CS, NREAD, AB, DB_IN,
        input  DB_OUT, nDTACK
    );

    modport slave (
        input  PAL_CS, PRI_CS, NREAD, AB, DB_IN,
        output DB_OUT, nDTACK
    );
endinterface
`default_nettype wire

// File: rtl/tmnt_palette_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tmnt_palette_mixer
// Description : Layer priority resolve, 1024x16 palette lookup and registered
//               RGB555 output; arbitrates 68000 byte accesses to the palette
//               around the pixel read slot with a DTACK handshake.
//               Optional macro SHADOW_EN adds the SHA shadow input.
// Revision    : 1.0 - initial release
// ============================================================================
module tmnt_palette_mixer #(
    parameter int PAL_AW      = 10,
    parameter bit PRI_DEFAULT = 1'b0
) (
    input  wire logic        clk_24M,
    input  wire logic        nRES,
    input  wire logic        V6M,
    input  wire logic [7:0]  VA,
    input  wire logic [7:0]  VB,
    input  wire logic [7:0]  FX,
    input  wire logic [7:0]  SPR,
    input  wire logic        NCBLK,
`ifdef SHADOW_EN
    input  wire logic        SHA,
`endif
    tmnt_palette_mixer_if.slave cpu,
    output logic [4:0]       RED,
    output logic [4:0]       GREEN,
    output logic [4:0]       BLUE
);

    localparam logic [1:0] ID_FX  = 2'd0;
    localparam logic [1:0] ID_A   = 2'd1;
    localparam logic [1:0] ID_B   = 2'd2;
    localparam logic [1:0] ID_SPR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

    // Palette storage; contents survive reset.
    logic [15:0] pal_ram [0:(1<<PAL_AW)-1];

    logic              v6m_d;
    logic              edge_e;
    logic              pix_slot;
    logic              pri;

    logic [1:0]        mix_id;
    logic [9:0]        mix_idx;
    logic              shade_next;

    logic [9:0]        pix_idx;
    logic [PAL_AW-1:0] pix_addr;
    logic              pix_blank_n;
    logic              pix_shade;
    logic [14:0]       pix_rgb;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              cpu_exec;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [PAL_AW-1:0] cpu_entry;
    logic [15:0]       cpu_word;
    logic [7:0]        db_out_q;

    assign edge_e    = ~v6m_d & V6M;
    assign pix_addr  = PAL_AW'(pix_idx);
    assign pix_rgb   = pal_ram[pix_addr][14:0];
    assign cpu_entry = cpu.AB[PAL_AW:1];
    assign cpu_word  = pal_ram[cpu_entry];
    assign cpu_wr    = cpu_exec & ~cpu.NREAD;
    assign cpu_rd    = cpu_exec &  cpu.NREAD;

    assign cpu.DB_OUT = db_out_q;
    assign cpu.nDTACK = (state != ST_ACK);

    // Priority resolve: a pen of 0 is transparent; B doubles as the backdrop.
    always_comb begin
        mix_id = ID_B;
        if (FX[3:0] != 4'd0) begin
            mix_id = ID_FX;
        end else if (pri) begin
            if (VA[3:0] != 4'd0)       mix_id = ID_A;
            else if (SPR[3:0] != 4'd0) mix_id = ID_SPR;
        end else begin
            if (SPR[3:0] != 4'd0)      mix_id = ID_SPR;
            else if (VA[3:0] != 4'd0)  mix_id = ID_A;
        end
        case (mix_id)
            ID_FX:   mix_idx = {ID_FX,  FX};
            ID_A:    mix_idx = {ID_A,   VA};
            ID_SPR:  mix_idx = {ID_SPR, SPR};
            default: mix_idx = {ID_B,   VB};
        endcase
    end

`ifdef SHADOW_EN
    assign shade_next = SHA & (mix_id != ID_FX);
`else
    assign shade_next = 1'b0;
`endif

    // V6M edge detect and pixel-index capture at cycle E.
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            v6m_d       <= 1'b1;
            pix_slot    <= 1'b0;
            pix_idx     <= 10'd0;
            pix_blank_n <= 1'b0;
            pix_shade   <= 1'b0;
        end else begin
            v6m_d    <= V6M;
            pix_slot <= edge_e;
            if (edge_e) begin
                pix_idx     <= mix_idx;
                pix_blank_n <= NCBLK;
                pix_shade   <= shade_next;
            end
        end
    end

    // Pixel slot read feeds the RGB registers; blank beats shadow.
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            RED   <= 5'd0;
            GREEN <= 5'd0;
            BLUE  <= 5'd0;
        end else if (pix_slot) begin
            if (!pix_blank_n) begin
                RED   <= 5'd0;
                GREEN <= 5'd0;
                BLUE  <= 5'd0;
            end else if (pix_shade) begin
                RED   <= {1'b0, pix_rgb[4:1]};
                GREEN <= {1'b0, pix_rgb[9:6]};
                BLUE  <= {1'b0, pix_rgb[14:11]};
            end else begin
                RED   <= pix_rgb[4:0];
                GREEN <= pix_rgb[9:5];
                BLUE  <= pix_rgb[14:10];
            end
        end
    end

    // Priority-mode register; takes effect at the next mix.
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            pri <= PRI_DEFAULT;
        end else if (cpu.PRI_CS) begin
            pri <= cpu.DB_IN[0];
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbiter next state: a pending access waits out the pixel slot.
    always_comb begin
        state_nxt = state;
        cpu_exec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu.PAL_CS) state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (!pix_slot) begin
                    cpu_exec  = 1'b1;
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!cpu.PAL_CS) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // CPU byte write; AB[0]=0 selects the high byte.
    always_ff @(posedge clk_24M) begin
        if (cpu_wr) begin
            if (cpu.AB[0]) pal_ram[cpu_entry][7:0]  <= cpu.DB_IN;
            else           pal_ram[cpu_entry][15:8] <= cpu.DB_IN;
        end
    end

    // CPU read data register.
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            db_out_q <= 8'd0;
        end else if (cpu_rd) begin
            db_out_q <= cpu.AB[0] ? cpu_word[7:0] : cpu_word[15:8];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmnt_palette_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmnt_palette_mixer
// Description : Directed self-checking bench for tmnt_palette_mixer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmnt_palette_mixer;

    logic       clk_24M = 1'b0;
    logic       nRES;
    logic       V6M;
    logic [7:0] VA, VB, FX, SPR;
    logic       NCBLK;
`ifdef SHADOW_EN
    logic       SHA;
`endif
    logic [4:0] RED, GREEN, BLUE;

    int vectors     = 0;
    int miscompares = 0;

    tmnt_palette_mixer_if #(.PAL_AW(10)) bus ();

    tmnt_palette_mixer #(.PAL_AW(10), .PRI_DEFAULT(1'b0)) dut (
        .clk_24M (clk_24M),
        .nRES    (nRES),
        .V6M     (V6M),
        .VA      (VA),
        .VB      (VB),
        .FX      (FX),
        .SPR     (SPR),
        .NCBLK   (NCBLK),
`ifdef SHADOW_EN
        .SHA     (SHA),
`endif
        .cpu     (bus.slave),
        .RED     (RED),
        .GREEN   (GREEN),
        .BLUE    (BLUE)
    );

    always #5 clk_24M = ~clk_24M;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Expected {RED,GREEN,BLUE} for a palette word {x,B,G,R}.
    function automatic logic [14:0] rgb_of(input logic [15:0] e);
        return {e[4:0], e[9:5], e[14:10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_access(input logic rd, input logic [10:0] addr,
                              input logic [7:0] data, input string tag);
        int lat;
        @(negedge clk_24M);
        bus.PAL_CS = 1'b1;
        bus.NREAD  = rd;
        bus.AB     = addr;
        bus.DB_IN  = data;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_24M);
            lat++;
            if (!bus.nDTACK) break;
        end
        chk({tag, "_lat"}, lat, 2);
        if (rd) chk({tag, "_data"}, bus.DB_OUT, data);
        @(negedge clk_24M);
        chk({tag, "_hold"}, bus.nDTACK, 1'b0);
        bus.PAL_CS = 1'b0;
        @(negedge clk_24M);
        chk({tag, "_rel"}, bus.nDTACK, 1'b1);
    endtask

    task automatic write_entry(input logic [9:0] idx, input logic [15:0] val);
        cpu_access(1'b0, {idx, 1'b0}, val[15:8], "wr_hi");
        cpu_access(1'b0, {idx, 1'b1}, val[7:0],  "wr_lo");
    endtask

    task automatic set_pri(input logic v);
        @(negedge clk_24M);
        bus.PRI_CS = 1'b1;
        bus.DB_IN  = {7'd0, v};
        @(negedge clk_24M);
        bus.PRI_CS = 1'b0;
        chk("pri_no_dtack", bus.nDTACK, 1'b1);
    endtask

    task automatic pixel(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                         input logic [7:0] s, input logic nb, input logic [14:0] exp,
                         input string tag);
        @(negedge clk_24M);
        VA = a; VB = b; FX = f; SPR = s; NCBLK = nb;
        V6M = 1'b1;
        @(negedge clk_24M);
        @(negedge clk_24M);
        chk(tag, {RED, GREEN, BLUE}, exp);
        V6M = 1'b0;
        @(negedge clk_24M);
        @(negedge clk_24M);
    endtask

    initial begin
        nRES = 1'b0; V6M = 1'b0;
        VA = 8'd0; VB = 8'd0; FX = 8'd0; SPR = 8'd0; NCBLK = 1'b1;
`ifdef SHADOW_EN
        SHA = 1'b0;
`endif
        bus.PAL_CS = 1'b0; bus.PRI_CS = 1'b0; bus.NREAD = 1'b1;
        bus.AB = 11'd0; bus.DB_IN = 8'd0;

        // Reset state
        repeat (3) @(negedge clk_24M);
        chk("rst_rgb",    {RED, GREEN, BLUE}, 15'd0);
        chk("rst_db_out", bus.DB_OUT, 8'd0);
        chk("rst_dtack",  bus.nDTACK, 1'b1);
        nRES = 1'b1;
        repeat (2) @(negedge clk_24M);

        // Palette preload through the CPU port
        write_entry(10'h105, 16'h7C1F);
        write_entry(10'h334, 16'h1234);
        write_entry(10'h112, 16'h5678);
        write_entry(10'h001, 16'h2AD5);
        write_entry(10'h250, 16'h6318);
`ifdef SHADOW_EN
        write_entry(10'h377, 16'h7FFF);
`endif

        // Basic lookup and hold with V6M idle
        pixel(8'h05, 8'h00, 8'h00, 8'h00, 1'b1, {5'd31, 5'd0, 5'd31}, "pix_105");
        repeat (5) @(negedge clk_24M);
        chk("rgb_hold", {RED, GREEN, BLUE}, {5'd31, 5'd0, 5'd31});

        // Priority modes
        pixel(8'h12, 8'h00, 8'h00, 8'h34, 1'b1, rgb_of(16'h1234), "pri0_spr");
        pixel(8'h12, 8'h00, 8'h01, 8'h34, 1'b1, rgb_of(16'h2AD5), "pri0_fx");
        set_pri(1'b1);
        pixel(8'h12, 8'h00, 8'h00, 8'h34, 1'b1, rgb_of(16'h5678), "pri1_a");
        pixel(8'h12, 8'h00, 8'h01, 8'h34, 1'b1, rgb_of(16'h2AD5), "pri1_fx");
        set_pri(1'b0);

        // Backdrop and blank
        pixel(8'h00, 8'h50, 8'h00, 8'h00, 1'b1, rgb_of(16'h6318), "backdrop");
        pixel(8'h00, 8'h50, 8'h00, 8'h00, 1'b0, 15'd0,            "blank");

        // Byte writes into entry 0x105
        cpu_access(1'b0, 11'h20A, 8'h3F, "wr_20A");
        cpu_access(1'b0, 11'h20B, 8'hE0, "wr_20B");
        pixel(8'h05, 8'h00, 8'h00, 8'h00, 1'b1, rgb_of(16'h3FE0), "pix_3FE0");

        // Write executing in cycle E is seen by the following pixel read
        @(negedge clk_24M);
        bus.PAL_CS = 1'b1; bus.NREAD = 1'b0; bus.AB = 11'h20B; bus.DB_IN = 8'h1F;
        @(negedge clk_24M);
        VA = 8'h05; VB = 8'h00; FX = 8'h00; SPR = 8'h00; NCBLK = 1'b1;
        V6M = 1'b1;
        @(negedge clk_24M);
        chk("coll_dtack", bus.nDTACK, 1'b0);
        @(negedge clk_24M);
        chk("coll_rgb", {RED, GREEN, BLUE}, rgb_of(16'h3F1F));
        bus.PAL_CS = 1'b0; V6M = 1'b0;
        @(negedge clk_24M);
        chk("coll_rel", bus.nDTACK, 1'b1);
        repeat (2) @(negedge clk_24M);

        // Read requested in cycle E is deferred past the pixel slot
        @(negedge clk_24M);
        V6M = 1'b1;
        bus.PAL_CS = 1'b1; bus.NREAD = 1'b1; bus.AB = 11'h20A;
        @(negedge clk_24M);
        chk("defer_e1", bus.nDTACK, 1'b1);
        @(negedge clk_24M);
        chk("defer_e2", bus.nDTACK, 1'b1);
        chk("defer_rgb", {RED, GREEN, BLUE}, rgb_of(16'h3F1F));
        @(negedge clk_24M);
        chk("defer_ack",  bus.nDTACK, 1'b0);
        chk("defer_data", bus.DB_OUT, 8'h3F);
        bus.PAL_CS = 1'b0; V6M = 1'b0;
        @(negedge clk_24M);
        chk("defer_rel", bus.nDTACK, 1'b1);
        repeat (2) @(negedge clk_24M);

        // Reset while a write is pending behind the pixel slot
        @(negedge clk_24M);
        V6M = 1'b1;
        bus.PAL_CS = 1'b1; bus.NREAD = 1'b0; bus.AB = 11'h20A; bus.DB_IN = 8'h00;
        @(negedge clk_24M);
        nRES = 1'b0;
        #1;
        chk("rstp_dtack", bus.nDTACK, 1'b1);
        chk("rstp_rgb",   {RED, GREEN, BLUE}, 15'd0);
        bus.PAL_CS = 1'b0;
        @(negedge clk_24M);
        nRES = 1'b1;
        V6M  = 1'b0;
        repeat (2) @(negedge clk_24M);
        cpu_access(1'b1, 11'h20A, 8'h3F, "rstp_keep");

        // Reset while acknowledging drops nDTACK at once
        @(negedge clk_24M);
        bus.PAL_CS = 1'b1; bus.NREAD = 1'b1; bus.AB = 11'h20B;
        repeat (2) @(negedge clk_24M);
        chk("rsta_ack", bus.nDTACK, 1'b0);
        nRES = 1'b0;
        #1;
        chk("rsta_dtack", bus.nDTACK, 1'b1);
        chk("rsta_dbout", bus.DB_OUT, 8'd0);
        bus.PAL_CS = 1'b0;
        @(negedge clk_24M);
        nRES = 1'b1;
        repeat (2) @(negedge clk_24M);

        // PRI back at its default after reset
        pixel(8'h12, 8'h00, 8'h00, 8'h34, 1'b1, rgb_of(16'h1234), "pri_after_rst");

`ifdef SHADOW_EN
        SHA = 1'b1;
        pixel(8'h00, 8'h00, 8'h00, 8'h77, 1'b1, {5'd15, 5'd15, 5'd15}, "shadow_spr");
        pixel(8'h00, 8'h00, 8'h01, 8'h77, 1'b1, rgb_of(16'h2AD5),      "shadow_fx");
        pixel(8'h00, 8'h00, 8'h00, 8'h77, 1'b0, 15'd0,                 "shadow_blank");
        SHA = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmnt_palette_mixer.md
Name: tmnt_palette_mixer

Overview:
- Downstream stage of the tilemap plane pipeline. Consumes per-pixel pen codes for tile layers A, B, FIX and the sprite layer.
- Resolves layer priority, looks up a CPU-writable 1024 x 16 palette RAM, and outputs registered RGB555 video for the video DAC.
- Arbitrates 68000 byte accesses to the palette RAM around pixel reads and returns a DTACK handshake.

Parameters:
- PAL_AW, 10, palette entry address width (entries = 2**PAL_AW).
- PRI_DEFAULT, 0, reset value of the priority-mode bit.

Ports:
- clk_24M  in  1  sole clock.
- nRES  in  1  asynchronous active-low reset.
- V6M  in  1  pixel clock level from the plane stage; sampled, never used as a clock.
- VA  in  8  layer A code {pal[3:0], pen[3:0]}.
- VB  in  8  layer B code, same format.
- FX  in  8  FIX layer code, same format.
- SPR  in  8  sprite code, same format.
- NCBLK  in  1  composite blank, active low.
- PAL_CS  in  1  CPU palette access request, active high.
- PRI_CS  in  1  CPU priority-register write strobe, active high; DB_IN[0] is the data.
- NREAD  in  1  1 = CPU read, 0 = CPU write.
- AB  in  PAL_AW+1  CPU byte address.
- DB_IN  in  8  CPU write data.
- DB_OUT  out  8  CPU read data.
- nDTACK  out  1  access acknowledge, active low.
- RED, GREEN, BLUE  out  5 each  pixel colour.

Behaviour:
- Reset (async, nRES low): RED/GREEN/BLUE = 0, DB_OUT = 0, nDTACK = 1, PRI = PRI_DEFAULT, arbiter idle, V6M delay register = 1. Palette RAM contents are not cleared.
- Edge detect: cycle E is the clk_24M cycle where the registered V6M is 0 and V6M is 1. There is exactly one E per V6M period.
- Cycle E, mix:
  - A pen of 0 is transparent.
  - PRI=0 order: FX > SPR > A > B. PRI=1 order: FX > A > SPR > B.
  - Index = {layer_id[1:0], code[7:0]} with layer ids FX=0, A=1, B=2, SPR=3.
  - If all four pens are 0, index = {2'd2, VB} (layer B backdrop entry).
  - NCBLK is registered together with the index.
- Cycle E+1: the palette RAM is read at the index. This cycle is the pixel slot.
- Cycle E+2: RGB registers load from the entry format {x, B[14:10], G[9:5], R[4:0]}; 0 if the blank sampled at E was low. RGB is held until the next E+2.
- Pixel latency: 2 clk_24M cycles from E.
- RAM byte map: AB[0]=0 is the high byte [15:8]; AB[0]=1 is the low byte [7:0]; AB[PAL_AW:1] is the entry.
- CPU arbiter states IDLE -> PEND -> ACK -> IDLE:
  - IDLE -> PEND: on a cycle with PAL_CS=1.
  - PEND: the access executes in the first cycle that is not a pixel slot. On a write, the byte is written. On a read, DB_OUT is loaded. The pixel read always wins a collision.
  - PEND -> ACK: the cycle after execution; nDTACK=0.
  - ACK -> IDLE: when PAL_CS=0; nDTACK=1 the next cycle.
  - Only one access per PAL_CS assertion.
  - Worst-case PAL_CS-to-nDTACK latency: 3 cycles.
- Same-entry collision: a CPU write in the cycle before a pixel slot is visible to that pixel read.
- PRI_CS=1: PRI <= DB_IN[0] the next cycle. The new PRI is used from the next E. PRI_CS does not touch nDTACK.
- Reset mid-access: a PEND write that has not executed is discarded; nDTACK returns to 1 immediately.
- V6M stuck at 0 or 1: no E, RGB holds, CPU accesses execute within 1 cycle.

Optional Feature:
- Macro SHADOW_EN.
- When defined:
  - Extra input SHA (1 bit), registered at E.
  - If SHA=1 and the winning layer is not FX, each RGB component is shifted right by 1 at E+2.
  - Blank takes precedence over shadow.
- When undefined: no SHA port; RGB is the unmodified palette entry.

Test Plan:
- Reset, then preload entry 0x105 = 0x7C1F. VA=0x05, others 0, NCBLK=1, PRI=0, toggle V6M -> RGB = (31,0,31) two cycles after the V6M rise.
- Priority: VA=0x12, SPR=0x34, FX=0x00. PRI=0 -> index 0x334. PRI=1 -> index 0x112. FX=0x01 -> index 0x001 in both modes.
- All pens 0, VB=0x50 -> index 0x250. Same pixel with NCBLK=0 -> RGB = 0.
- CPU writes AB=0x20A data 0x3F, then AB=0x20B data 0xE0 -> entry 0x105 = 0x3FE0. Each write has nDTACK=0 within 3 cycles, held until PAL_CS drops, then 1 one cycle later.
- PAL_CS asserted in cycle E -> execution deferred past E+1, no pixel corruption. Read AB=0x20A returns 0x3F on DB_OUT.
- Assert nRES while PEND -> nDTACK=1 at once and the RAM entry is unchanged. With SHADOW_EN: SHA=1, sprite winner 0x7FFF -> RGB (15,15,15).
